instr_fetch_unit: RTL and testbench

//  Supplies the core's instruction-input port (i_req_instr / i_instr). Fetches sequential words

---
 rtl/core_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants for the core front end: widths, the canonical NOP and the
// instruction-fetch state encoding.
package core_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with wrap-bit pointers, flush, and occupancy count.
// Storage is write-only-when-pushed; the head word is read combinationally.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             push_ok, pop_ok;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction prefetcher: credit-limited imem requests, in-order
// responses buffered as {pc,word}, one instruction per cycle to the core.
module instr_fetch_unit #(
  parameter int                        XLEN       = core_pkg::XLEN,
  parameter logic [XLEN-1:0]           RESET_PC   = core_pkg::RESET_PC_DEFAULT,
  parameter int                        FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic                         o_imem_req,
  output logic [XLEN-1:0]              o_imem_addr,
  input  logic                         i_imem_gnt,
  input  logic                         i_imem_rvalid,
  input  logic [XLEN-1:0]              i_imem_rdata,
  output logic                         o_req_instr,
  output logic [31:0]                  o_instr,
  output logic [XLEN-1:0]              o_pc,
  input  logic                         i_stall,
  input  logic                         i_redirect,
  input  logic [XLEN-1:0]              i_redirect_pc
);

  import core_pkg::*;

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   in_flight_q, in_flight_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty, fifo_full;
  logic [XLEN+INSTR_W-1:0] fifo_head;
  logic [XLEN-1:0]         redirect_pc;
  logic                    issue, resp, push, pop;

  assign redirect_pc = {i_redirect_pc[XLEN-1:2], 2'b00};

  // Credits: a request is only raised when its response is sure to find a FIFO slot.
  assign o_imem_req  = (state_q == ST_RUN) &&
                       (({1'b0, in_flight_q} + {1'b0, fifo_count}) < DEPTH_C);
  assign o_imem_addr = fetch_pc_q;
  assign issue       = o_imem_req && i_imem_gnt;
  assign resp        = i_imem_rvalid && (in_flight_q != '0);
  assign in_flight_d = in_flight_q + CW'(issue) - CW'(resp);

  assign push        = resp && (state_q == ST_RUN) && !i_redirect;
  assign o_req_instr = !fifo_empty && (state_q == ST_RUN);
  assign pop         = o_req_instr && !i_stall && !i_redirect;
  assign o_instr     = fifo_empty ? NOP_INSTR : fifo_head[INSTR_W-1:0];
  assign o_pc        = fifo_empty ? resp_pc_q : fifo_head[XLEN+INSTR_W-1:INSTR_W];

  fetch_fifo #(
    .WIDTH (XLEN + INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({resp_pc_q, i_imem_rdata[INSTR_W-1:0]}),
    .pop     (pop),
    .flush   (i_redirect),
    .rdata   (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
        if (push)  resp_pc_d  = resp_pc_q + XLEN'(4);
        if (i_redirect) begin
          fetch_pc_d = redirect_pc;
          resp_pc_d  = redirect_pc;
          // Requests still outstanding belong to the old stream and must be swallowed.
          if (in_flight_d != '0) begin
            state_d   = ST_DRAIN;
            discard_d = in_flight_d;
          end
        end
      end
      ST_DRAIN: begin
        if (resp) discard_d = discard_q - CW'(1);
        if (i_redirect) begin
          fetch_pc_d = redirect_pc;
          resp_pc_d  = redirect_pc;
        end
        if (discard_d == '0) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      in_flight_q <= '0;
      discard_q   <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      in_flight_q <= in_flight_d;
      discard_q   <= discard_d;
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!reset_n)
    !(i_imem_rvalid && (in_flight_q == '0)));

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && fifo_full));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order imem model returning word=addr, and a
// scoreboard of expected {pc} deliveries filled as live responses are driven.
module tb_instr_fetch_unit;
  import core_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        o_imem_req, o_req_instr;
  logic [31:0] o_imem_addr, o_instr, o_pc;
  logic        i_imem_gnt = 1'b1, i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        i_stall = 1'b0, i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .XLEN       (32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_req_instr   (o_req_instr),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] sb_q[$];
  int          cyc = 0;
  int          epoch = 0;
  int          drops = 0;
  int          mem_lat = 1;
  int          delivered = 0;
  int          combo_cnt = 0;
  logic [31:0] exp_fetch = RST_PC;
  bit          awaiting_first = 1'b0;
  logic [31:0] first_pc = 32'h0;
  int          first_drops = 0;
  bit          hold_v = 1'b0;
  logic [31:0] hold_pc, hold_instr;

  // imem response driver: in-order, each response due mem_lat cycles after its grant.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset_n || pend.size() == 0 || pend[0].due > cyc) begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = pend[0].addr;
    end
  end

  // Monitor and scoreboard, sampling mid-cycle what the next rising edge will commit.
  always @(negedge clk) begin
    req_t r;
    int   n_pend, n_sb;
    if (!reset_n) begin
      pend.delete();
      sb_q.delete();
      exp_fetch      = RST_PC;
      epoch++;
      hold_v         = 1'b0;
      awaiting_first = 1'b0;
    end else begin
      n_pend = pend.size();
      n_sb   = sb_q.size();
      check("req_instr_valid", o_req_instr, (n_sb != 0));
      if (hold_v) begin
        check("stall_hold_pc", o_pc, hold_pc);
        check("stall_hold_instr", o_instr, hold_instr);
      end
      hold_v     = o_req_instr && i_stall && !i_redirect;
      hold_pc    = o_pc;
      hold_instr = o_instr;

      if (o_req_instr && !i_stall && !i_redirect) begin
        check("deliver_expected", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          logic [31:0] e;
          e = sb_q.pop_front();
          check("deliver_pc", o_pc, e);
          check("deliver_instr", o_instr, e);
        end
        delivered++;
        if (awaiting_first) begin
          first_pc       = o_pc;
          first_drops    = drops;
          awaiting_first = 1'b0;
        end
      end

      if (i_imem_rvalid) begin
        check("rvalid_tracked", (pend.size() != 0), 1);
        if (pend.size() != 0) begin
          r = pend.pop_front();
          if (r.epoch == epoch && !i_redirect) sb_q.push_back(r.addr);
          else drops++;
        end
        if (i_redirect && o_req_instr && !i_stall) combo_cnt++;
      end

      if (o_imem_req && i_imem_gnt) begin
        check("credit_limit", (n_pend + n_sb < DEPTH), 1);
        check("fetch_addr", o_imem_addr, exp_fetch);
        pend.push_back('{addr: exp_fetch, epoch: epoch, due: cyc + mem_lat});
        exp_fetch = exp_fetch + 32'd4;
      end

      if (i_redirect) begin
        sb_q.delete();
        exp_fetch      = {i_redirect_pc[31:2], 2'b00};
        epoch++;
        drops          = 0;
        awaiting_first = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check({tag, "_imem_req"}, o_imem_req, 0);
    check({tag, "_imem_addr"}, o_imem_addr, RST_PC);
    check({tag, "_req_instr"}, o_req_instr, 0);
    check({tag, "_instr_nop"}, o_instr, NOP_INSTR);
    check({tag, "_pc"}, o_pc, RST_PC);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check({tag, "_idle_no_req"}, o_imem_req, 0);
    @(posedge clk);
    #1;
    check({tag, "_first_req"}, o_imem_req, 1);
    check({tag, "_first_addr"}, o_imem_addr, RST_PC);
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    i_imem_gnt = 1'b0;
    while ((pend.size() != 0 || sb_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    check({tag, "_quiesce"}, (pend.size() == 0 && sb_q.size() == 0), 1);
  endtask

  task automatic wait_first(input string tag);
    int n = 0;
    while (awaiting_first && n < 200) begin
      step();
      n++;
    end
    check({tag, "_first_delivered"}, awaiting_first, 0);
  endtask

  task automatic redirect_pulse(input logic [31:0] pc, input logic gnt_during);
    i_redirect    = 1'b1;
    i_redirect_pc = pc;
    i_imem_gnt    = gnt_during;
    step();
    i_redirect    = 1'b0;
  endtask

  initial begin
    int d0, c0;

    // 1: reset, zero-wait streaming from RESET_PC at one instruction per cycle
    apply_reset("rst");
    i_imem_gnt = 1'b1;
    mem_lat    = 1;
    repeat (5) step();
    d0 = delivered;
    repeat (20) step();
    check("stream_rate", delivered - d0, 20);

    // 2: five stall cycles, then the stream must resume at full rate
    i_stall = 1'b1;
    repeat (5) step();
    i_stall = 1'b0;
    d0 = delivered;
    repeat (10) step();
    check("stall_recover_rate", delivered - d0, 10);

    // 3: three requests in flight when redirected to 0x100
    wait_quiet("t3");
    mem_lat    = 10;
    i_imem_gnt = 1'b1;
    repeat (3) step();
    redirect_pulse(32'h0000_0100, 1'b0);
    i_imem_gnt = 1'b1;
    mem_lat    = 1;
    wait_first("t3");
    check("t3_first_pc", first_pc, 32'h0000_0100);
    check("t3_drops", first_drops, 3);

    // 4: unaligned redirect with nothing pending stays in RUN
    wait_quiet("t4");
    redirect_pulse(32'h0000_0203, 1'b0);
    check("t4_req_next", o_imem_req, 1);
    check("t4_addr_next", o_imem_addr, 32'h0000_0200);
    i_imem_gnt = 1'b1;
    wait_first("t4");
    check("t4_first_pc", first_pc, 32'h0000_0200);
    check("t4_drops", first_drops, 0);

    // 5: redirect coinciding with an rvalid and a would-be consume
    repeat (10) step();
    c0 = combo_cnt;
    redirect_pulse(32'h0000_0300, 1'b0);
    check("t5_combo_hit", combo_cnt - c0, 1);
    check("t5_req_next", o_imem_req, 1);
    check("t5_addr_next", o_imem_addr, 32'h0000_0300);
    i_imem_gnt = 1'b1;
    wait_first("t5");
    check("t5_first_pc", first_pc, 32'h0000_0300);

    // Address wrap at the top of memory
    redirect_pulse(32'hFFFF_FFF8, 1'b1);
    repeat (12) step();

    // Randomised grant, stall, latency and redirect traffic
    for (int i = 0; i < 400; i++) begin
      i_imem_gnt = ($urandom_range(0, 3) != 0);
      i_stall    = ($urandom_range(0, 3) == 0);
      mem_lat    = $urandom_range(1, 4);
      if ($urandom_range(0, 24) == 0) begin
        i_redirect    = 1'b1;
        i_redirect_pc = $urandom();
      end else begin
        i_redirect = 1'b0;
      end
      step();
    end
    i_redirect = 1'b0;
    i_stall    = 1'b0;
    i_imem_gnt = 1'b1;
    mem_lat    = 1;
    repeat (10) step();

    // 6: asynchronous reset pulse mid-stream, fetch restarts at RESET_PC
    apply_reset("midrst");
    d0 = delivered;
    repeat (10) step();
    check("midrst_stream_rate", delivered - d0, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
